// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-requester AXI-Lite write arbiter.
//   arb_state_e  : arbiter FSM state encoding (2 bits)
//   RESP_OKAY    : AXI OKAY response code
//   RESP_SLVERR  : AXI SLVERR response code
//   STAT_WIDTH   : width of each per-requester grant counter
//   sat_inc()    : saturating increment for the grant counters
package axi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StWaitB = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 2;
  localparam int unsigned STAT_WIDTH  = 16;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection with its last-grant pointer.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (pointer resets to 1, so requester 0 wins first)
//   req      : request vector, one bit per requester
//   grant_en : a grant is taken this cycle if any request is present
//   g        : index of the winning requester (combinational)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       g
);

  logic last_g_q;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    g = 1'b0;
    if (req[0] && req[1]) begin
      g = ~last_g_q;
    end else begin
      g = req[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_g_q <= 1'b1;
    end else if (grant_en && (|req)) begin
      last_g_q <= g;
    end
  end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// Two-requester AXI-Lite write arbiter sharing one downstream AW/W/B path.
// One complete write is in flight at a time; the winner is picked round-robin among
// requesters presenting both AW and W valid, its payload is registered and forwarded
// downstream, and the downstream response is routed back to it.
//
// Ports:
//   axi_aclk, axi_aresetn          : clock, asynchronous active-low reset
//   s_axi_aw*/s_axi_w*/s_axi_b*    : two upstream requesters, packed per requester
//   s_axi_bresp                    : response shared by both requesters (0 unless responding)
//   m_axi_aw*/m_axi_w*/m_axi_b*    : single downstream write channel set
//   grant_cnt                      : per-requester saturating grant counters
//                                    (present only when ARB_STATS_EN is defined)
module axi_lite_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [2*ADDR_WIDTH-1:0]       s_axi_awaddr,
  input  logic [1:0]                    s_axi_awvalid,
  output logic [1:0]                    s_axi_awready,
  input  logic [2*DATA_WIDTH-1:0]       s_axi_wdata,
  input  logic [2*(DATA_WIDTH/8+1)-1:0] s_axi_wstrb,
  input  logic [1:0]                    s_axi_wvalid,
  output logic [1:0]                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]         s_axi_bresp,
  output logic [1:0]                    s_axi_bvalid,
  input  logic [1:0]                    s_axi_bready,
  output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [DATA_WIDTH/8:0]         m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [RESP_WIDTH-1:0]         m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
`ifdef ARB_STATS_EN
  ,
  output logic [2*STAT_WIDTH-1:0]       grant_cnt
`endif
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8 + 1;

  arb_state_e              state_q, state_d;
  logic [1:0]              req;
  logic                    idle;
  logic                    grant;
  logic                    win;
  logic                    g_q;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [RESP_WIDTH-1:0]   bresp_q;

  // A lone AW or lone W is not a request.
  assign req   = s_axi_awvalid & s_axi_wvalid;
  assign idle  = (state_q == StIdle);
  assign grant = idle && (|req);

  rr_arb2 u_rr_arb2 (
    .clk      (axi_aclk),
    .rst_n    (axi_aresetn),
    .req      (req),
    .grant_en (idle),
    .g        (win)
  );

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    s_axi_awready = 2'b00;
    s_axi_wready  = 2'b00;
    s_axi_bvalid  = 2'b00;
    s_axi_bresp   = '0;
    m_axi_bready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          s_axi_awready[win] = 1'b1;
          s_axi_wready[win]  = 1'b1;
          awvalid_d          = 1'b1;
          wvalid_d           = 1'b1;
          state_d            = StXfer;
        end
      end
      StXfer: begin
        // AW and W complete independently; leave once neither is outstanding.
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = StWaitB;
      end
      StWaitB: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = StResp;
      end
      StResp: begin
        s_axi_bvalid[g_q] = 1'b1;
        s_axi_bresp       = bresp_q;
        if (s_axi_bready[g_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= StIdle;
      g_q       <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      if (grant) begin
        g_q      <= win;
        awaddr_q <= win ? s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                        : s_axi_awaddr[ADDR_WIDTH-1:0];
        wdata_q  <= win ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                        : s_axi_wdata[DATA_WIDTH-1:0];
        wstrb_q  <= win ? s_axi_wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                        : s_axi_wstrb[STRB_WIDTH-1:0];
      end
      if ((state_q == StWaitB) && m_axi_bvalid) begin
        bresp_q <= m_axi_bresp;
      end
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;

`ifdef ARB_STATS_EN
  logic [STAT_WIDTH-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (grant) begin
      if (win) cnt1_q <= sat_inc(cnt1_q);
      else     cnt0_q <= sat_inc(cnt0_q);
    end
  end

  assign grant_cnt = {cnt1_q, cnt0_q};
`endif

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Randomized self-checking bench for axi_lite_wr_arbiter with a transaction-level model.
module tb_axi_lite_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8 + 1;
  localparam int RW = 3;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic [2*AW-1:0]   s_axi_awaddr = '0;
  logic [1:0]        s_axi_awvalid = '0;
  logic [1:0]        s_axi_awready;
  logic [2*DW-1:0]   s_axi_wdata = '0;
  logic [2*SW-1:0]   s_axi_wstrb = '0;
  logic [1:0]        s_axi_wvalid = '0;
  logic [1:0]        s_axi_wready;
  logic [RW-1:0]     s_axi_bresp;
  logic [1:0]        s_axi_bvalid;
  logic [1:0]        s_axi_bready = '0;
  logic [AW-1:0]     m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b0;
  logic [DW-1:0]     m_axi_wdata;
  logic [SW-1:0]     m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready = 1'b0;
  logic [RW-1:0]     m_axi_bresp = '0;
  logic              m_axi_bvalid = 1'b0;
  logic              m_axi_bready;
`ifdef ARB_STATS_EN
  logic [31:0]       grant_cnt;
`endif

  always #5 axi_aclk = ~axi_aclk;

  axi_lite_wr_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESP_WIDTH (RW)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Transaction-level model: at most one write outstanding, tracked by phase flags.
  int            last_g;
  bit            busy, aw_pend, w_pend, resp_known;
  logic [RW-1:0] exp_resp;
  int            cur_id;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [SW-1:0] cur_strb;
  int            gcnt [2];
  int            busy_cyc;

  // Stimulus state.
  bit            active [2];
  int            gap [2];
  int            lag [2];
  bit            sl_aw, sl_w;
  bit            alt_mode, post_rst, rst_done;
  int            alt_seen;
  logic [DW-1:0] alt_seq [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; aw_pend = 0; w_pend = 0; resp_known = 0; exp_resp = '0;
    last_g = 1; cur_id = 0; busy_cyc = 0;
    gcnt[0] = 0; gcnt[1] = 0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; gap[i] = 0; lag[i] = 0;
    end
    sl_aw = 0; sl_w = 0;
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    post_rst = 1;
  endtask

  // Sampled away from the clock edge; handshakes found here complete at the next posedge.
  task automatic sample(output logic [1:0] s_hs, output bit aw_hs, output bit w_hs,
                        output bit mb_hs);
    logic [1:0] req, exp_rdy, exp_bv;
    bit         sb_hs, exp_mbr;
    int         w;
    req = s_axi_awvalid & s_axi_wvalid;

    exp_bv = (busy && resp_known) ? (2'b01 << cur_id) : 2'b00;
    chk("s_bvalid", s_axi_bvalid, exp_bv);
    chk("s_bresp", s_axi_bresp, (busy && resp_known) ? exp_resp : '0);
    sb_hs = busy && resp_known && s_axi_bready[cur_id];

    chk("m_awvalid", m_axi_awvalid, aw_pend);
    if (aw_pend) chk("m_awaddr", m_axi_awaddr, cur_addr);
    aw_hs = aw_pend && m_axi_awready;
    chk("m_wvalid", m_axi_wvalid, w_pend);
    if (w_pend) begin
      chk("m_wdata", m_axi_wdata, cur_data);
      chk("m_wstrb", m_axi_wstrb, cur_strb);
    end
    w_hs = w_pend && m_axi_wready;

    exp_mbr = busy && !aw_pend && !w_pend && !resp_known;
    chk("m_bready", m_axi_bready, exp_mbr);
    mb_hs = exp_mbr && m_axi_bvalid;

    w = 0;
    exp_rdy = 2'b00;
    if (!busy && req != 2'b00) begin
      w = (req == 2'b11) ? 1 - last_g : (req[1] ? 1 : 0);
      exp_rdy = 2'b01 << w;
      if (post_rst) begin
        chk("post_reset_grant", s_axi_awready, 2'b01);
        post_rst = 0;
      end
    end
    chk("s_awready", s_axi_awready, exp_rdy);
    chk("s_wready", s_axi_wready, exp_rdy);
    s_hs = exp_rdy;

    if (aw_hs) aw_pend = 0;
    if (w_hs) w_pend = 0;
    if (mb_hs) begin
      resp_known = 1;
      exp_resp = m_axi_bresp;
    end
    if (sb_hs) begin
      busy = 0;
      resp_known = 0;
    end
    if (exp_rdy != 2'b00) begin
      busy = 1; aw_pend = 1; w_pend = 1;
      last_g = w; cur_id = w;
      cur_addr = s_axi_awaddr[w*AW +: AW];
      cur_data = s_axi_wdata[w*DW +: DW];
      cur_strb = s_axi_wstrb[w*SW +: SW];
      if (gcnt[w] < 65535) gcnt[w]++;
      if (alt_mode && alt_seen < 4) begin
        alt_seq[alt_seen] = cur_data;
        alt_seen++;
      end
    end
  endtask

  // Driven just after the posedge so combinational readies settle before sampling.
  task automatic drive(input logic [1:0] s_hs, input bit aw_hs, input bit w_hs,
                       input bit mb_hs);
    int mode;
    for (int i = 0; i < 2; i++) begin
      if (s_hs[i]) begin
        s_axi_awvalid[i] = 0;
        s_axi_wvalid[i]  = 0;
        active[i] = 0;
        gap[i] = alt_mode ? 0 : $urandom_range(0, 5);
      end else if (!active[i]) begin
        if (gap[i] > 0) begin
          gap[i]--;
        end else begin
          active[i] = 1;
          s_axi_awaddr[i*AW +: AW] = AW'($urandom);
          s_axi_wdata[i*DW +: DW]  = alt_mode ? ((i == 0) ? 32'h11 : 32'h22) : $urandom;
          s_axi_wstrb[i*SW +: SW]  = SW'($urandom);
          mode = (alt_mode || post_rst) ? 0 : $urandom_range(0, 2);
          lag[i] = $urandom_range(1, 3);
          s_axi_awvalid[i] = (mode != 2);
          s_axi_wvalid[i]  = (mode != 1);
        end
      end else if (!(s_axi_awvalid[i] && s_axi_wvalid[i])) begin
        // Lone AW or lone W held for a few cycles before the other half arrives.
        if (lag[i] > 0) lag[i]--;
        if (lag[i] == 0) begin
          s_axi_awvalid[i] = 1;
          s_axi_wvalid[i]  = 1;
        end
      end
    end
    if (aw_hs) sl_aw = 1;
    if (w_hs) sl_w = 1;
    if (mb_hs) begin
      m_axi_bvalid = 0;
      sl_aw = 0;
      sl_w = 0;
    end else if (sl_aw && sl_w && !m_axi_bvalid && (alt_mode || $urandom_range(0, 2) == 0)) begin
      m_axi_bvalid = 1;
      m_axi_bresp  = RW'($urandom_range(0, 7));
    end
    m_axi_awready = alt_mode || ($urandom_range(0, 99) < 50);
    m_axi_wready  = alt_mode || ($urandom_range(0, 99) < 60);
    s_axi_bready  = alt_mode ? 2'b11 : 2'($urandom);
  endtask

  initial begin
    logic [1:0] s_hs;
    bit aw_hs, w_hs, mb_hs;
    alt_mode = 0; alt_seen = 0; rst_done = 0;
    model_reset();
    repeat (2) @(negedge axi_aclk);
    chk("rst_m_awvalid", m_axi_awvalid, 0);
    chk("rst_m_wvalid", m_axi_wvalid, 0);
    chk("rst_m_bready", m_axi_bready, 0);
    chk("rst_s_bvalid", s_axi_bvalid, 0);
    chk("rst_m_wdata", m_axi_wdata, 0);
    axi_aresetn = 1;

    // Single write from requester 0, downstream always ready.
    @(posedge axi_aclk); #1;
    s_axi_awaddr = '0;
    s_axi_wdata = {32'h0, 32'd56};
    s_axi_wstrb = {5'h0, 5'd15};
    s_axi_awvalid = 2'b01; s_axi_wvalid = 2'b01;
    m_axi_awready = 1; m_axi_wready = 1; s_axi_bready = 2'b11;
    @(negedge axi_aclk);
    chk("d1_awready", s_axi_awready, 2'b01);
    chk("d1_wready", s_axi_wready, 2'b01);
    @(posedge axi_aclk); #1;
    s_axi_awvalid = 2'b00; s_axi_wvalid = 2'b00;
    @(negedge axi_aclk);
    chk("d1_m_awvalid", m_axi_awvalid, 1);
    chk("d1_m_wvalid", m_axi_wvalid, 1);
    chk("d1_m_awaddr", m_axi_awaddr, 8'h00);
    chk("d1_m_wdata", m_axi_wdata, 32'd56);
    chk("d1_m_wstrb", m_axi_wstrb, 5'd15);
    @(posedge axi_aclk); #1;
    m_axi_bvalid = 1; m_axi_bresp = 3'd0;
    @(negedge axi_aclk);
    chk("d1_m_bready", m_axi_bready, 1);
    chk("d1_m_awvalid_low", m_axi_awvalid, 0);
    chk("d1_s_bvalid_wait", s_axi_bvalid, 2'b00);
    @(posedge axi_aclk); #1;
    m_axi_bvalid = 0;
    @(negedge axi_aclk);
    chk("d1_s_bvalid", s_axi_bvalid, 2'b01);
    chk("d1_s_bresp", s_axi_bresp, 3'd0);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    chk("d1_s_bvalid_1cyc", s_axi_bvalid, 2'b00);

    @(posedge axi_aclk); #1;
    axi_aresetn = 0;
    model_reset();
    @(negedge axi_aclk);
    axi_aresetn = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      alt_mode = (cyc < 40);
      @(negedge axi_aclk);
      sample(s_hs, aw_hs, w_hs, mb_hs);
      busy_cyc = busy ? busy_cyc + 1 : 0;
      if (busy_cyc == 300) begin
        total++; bad++;
        $display("FAIL watchdog: transaction open %0d cycles, want fewer than 300", busy_cyc);
      end
      if (cyc == 40) begin
        chk("alt_count_ge4", alt_seen >= 4, 1);
        chk("alt_data0", alt_seq[0], 32'h11);
        chk("alt_data1", alt_seq[1], 32'h22);
        chk("alt_data2", alt_seq[2], 32'h11);
        chk("alt_data3", alt_seq[3], 32'h22);
      end
      @(posedge axi_aclk); #1;
      drive(s_hs, aw_hs, w_hs, mb_hs);
      if (!rst_done && cyc >= 1500 && (aw_pend || w_pend)) begin
        rst_done = 1;
        s_axi_awvalid = '0; s_axi_wvalid = '0;
        #1 axi_aresetn = 0;
        #1;
        chk("xrst_m_awvalid", m_axi_awvalid, 0);
        chk("xrst_m_wvalid", m_axi_wvalid, 0);
        chk("xrst_m_bready", m_axi_bready, 0);
        chk("xrst_s_bvalid", s_axi_bvalid, 0);
        chk("xrst_s_awready", s_axi_awready, 0);
        chk("xrst_s_bresp", s_axi_bresp, 0);
        model_reset();
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        axi_aresetn = 1;
      end
    end
    chk("reset_injected", rst_done, 1);
`ifdef ARB_STATS_EN
    chk("grant_cnt0", grant_cnt[15:0], gcnt[0]);
    chk("grant_cnt1", grant_cnt[31:16], gcnt[1]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_wr_arbiter.md
Name: axi_lite_wr_arbiter

Overview:
Two-requester AXI-Lite write arbiter that shares one downstream write path (AW, W and B channels) of the bus fabric.
- Grants one complete write transaction at a time using round-robin.
- Registers address, data and strobe, forwards them downstream, then routes the write response back to the granted requester.
- Sits between two upstream masters and the bus slave interface.

Parameters:
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 8, address width.
- RESP_WIDTH, 3, response width, matching the bus.

Ports:
- axi_aclk  in  1  single clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  2*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_axi_awvalid / s_axi_awready  in/out  2  per-requester AW handshake.
- s_axi_wdata  in  2*DATA_WIDTH  packed write data.
- s_axi_wstrb  in  2*(DATA_WIDTH/8+1)  packed strobes; width matches the bus.
- s_axi_wvalid / s_axi_wready  in/out  2  per-requester W handshake.
- s_axi_bresp  out  RESP_WIDTH  response, shared by both requesters.
- s_axi_bvalid / s_axi_bready  out/in  2  per-requester B handshake.
- m_axi_awaddr / m_axi_awvalid / m_axi_awready  out/out/in  ADDR_WIDTH/1/1  downstream AW channel.
- m_axi_wdata / m_axi_wstrb / m_axi_wvalid / m_axi_wready  out/out/out/in  DATA_WIDTH/(DATA_WIDTH/8+1)/1/1  downstream W channel.
- m_axi_bresp / m_axi_bvalid / m_axi_bready  in/in/out  RESP_WIDTH/1/1  downstream B channel.

Behaviour:
- Request: requester i is requesting when s_axi_awvalid[i] and s_axi_wvalid[i] are both high. A lone AW or lone W never wins arbitration.
- Round-robin: pointer last_g resets to 1, so requester 0 wins first. If both request, the one != last_g wins; if one requests, it wins. last_g updates on grant.
- FSM states: IDLE, XFER, WAIT_B, RESP.
- IDLE:
  - On a request, s_axi_awready[g] and s_axi_wready[g] go high combinationally in that same cycle (one cycle only).
  - At that edge: capture addr/data/strb and g; go to XFER.
  - No request: all readies low.
- XFER:
  - m_axi_awvalid and m_axi_wvalid are registered high from the first XFER cycle and held stable.
  - Each valid drops independently after its own handshake.
  - When both handshakes are done (same cycle or different cycles), go to WAIT_B.
- WAIT_B:
  - m_axi_bready = 1.
  - On m_axi_bvalid: capture m_axi_bresp into bresp_q; go to RESP.
- RESP:
  - s_axi_bvalid[g] = 1 and s_axi_bresp = bresp_q.
  - On s_axi_bready[g], go to IDLE.
  - If bready[g] is already high, bvalid lasts exactly 1 cycle.
- Output rules:
  - Non-granted requester: ready and bvalid stay 0 throughout.
  - s_axi_bresp = 0 outside RESP.
  - m_axi_bready = 0 outside WAIT_B.
- Latency with downstream always ready: upstream handshake at cycle 0, m valids cycles 1, WAIT_B cycle 2, s_bvalid cycle 1 after m_axi_bvalid. Minimum 4 cycles per transaction.
- Reset values: all valids/readies 0, payload registers 0, bresp_q 0, state IDLE, last_g 1.
- Reset mid-transaction: the transaction is abandoned immediately and no response is returned.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, 2*16 bits: per-requester 16-bit counters.
  - Each counter increments on its grant and saturates at 16'hFFFF.
  - Counters reset to 0.
- When not defined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package axi_arb_pkg holds:
  - FSM state encoding (2 bits).
  - RESP_OKAY = 0, RESP_SLVERR = 2.
  - STAT_WIDTH = 16.
- Sub-module rr_arb2: combinational winner selection plus the last_g pointer register, with inputs req[1:0] and grant_en and output g.

Test Plan:
1. Single write, downstream always ready. Req0 writes addr 0x00, data 56, strb 15; bresp 0 returned on cycle 3. Expect: m_axi_awaddr 0x00, m_axi_wdata 56 on cycle 1; s_axi_bvalid[0] = 1 with bresp 0; bvalid[1] never asserted.
2. Simultaneous requests, repeated. Req0 data 0x11, req1 data 0x22, both held. Expect: grants alternate 0,1,0,1; downstream data sequence 0x11, 0x22, 0x11, 0x22.
3. Downstream stalls. m_axi_awready delayed 3 cycles, m_axi_wready delayed 1 cycle. Expect: wvalid drops after 1 cycle; awvalid held with stable addr for 3 cycles; then WAIT_B.
4. Upstream B stall. Downstream returns bresp 2, s_axi_bready[1] low for 5 cycles. Expect: s_axi_bvalid[1] high with bresp 2 for 5 cycles; new requests ignored until the bready handshake.
5. Async reset in XFER. Expect: all outputs 0 immediately, no bvalid; next write is granted to requester 0.
6. With ARB_STATS_EN, 70000 grants to req0. Expect: grant_cnt[15:0] = 16'hFFFF, saturated.
